// File: rtl/rs_pkg.sv
// Shared RS(31,k) decoder definitions: symbol geometry, symbol type and the
// control-state encoding used by the FIFO, syndrome, CSEE and corrector stages.
package rs_pkg;

  localparam int unsigned SYM_W = 5;   // GF(2^5) symbol width
  localparam int unsigned N_SYM = 31;  // symbols per codeword
  localparam int unsigned CNT_W = 5;   // position counter width (0..N_SYM-1)

  typedef logic [SYM_W-1:0] sym_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/rs_sym_counter.sv
// Symbol position counter 0..N_SYM-1 with clear, enable and terminal-count flag.
// Holds at N_SYM-1 (no wrap) until cleared.
// Ports:
//   clk_i    rising-edge clock
//   rst_n_i  synchronous active-low reset
//   clr_i    force count to 0 (priority over enable)
//   en_i     advance by one position
//   cnt_o    current position
//   tc_o     high while cnt_o == N_SYM-1
module rs_sym_counter
  import rs_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  localparam logic [CNT_W-1:0] LastPos = CNT_W'(N_SYM - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;

  // Next position; the flag is computed from the next value so it stays registered.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_q) begin
      cnt_d = CNT_W'(cnt_q + 1'b1);
    end
    tc_d = (cnt_d == LastPos);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = tc_q;

endmodule

// File: rtl/rs_error_corrector.sv
// RS(31,k) final stage: reads the stored received word one symbol per cycle,
// XORs in the CSEE error magnitude and emits the corrected codeword with
// framing, a per-codeword correction count and fail status.
// Optional statistics counters are built when RS_CORR_STATS_EN is defined.
// Ports:
//   clock, reset      clock and synchronous active-low reset
//   start             new codeword ready (pulse); decode_fail sampled with it
//   sym_in            received symbol from the FIFO output register
//   err_loc, err_val  CSEE error flag / magnitude for the current position
//   fifo_rd           FIFO output-enable strobe (combinational)
//   dataout, dout_valid, dout_first, dout_last   corrected symbol stream
//   num_corr, corr_fail, corr_done               per-codeword status
//   cw_count, fail_count                         (RS_CORR_STATS_EN only)
module rs_error_corrector
  import rs_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             decode_fail,
  input  logic [SYM_W-1:0] sym_in,
  input  logic             err_loc,
  input  logic [SYM_W-1:0] err_val,
  output logic             fifo_rd,
  output logic [SYM_W-1:0] dataout,
  output logic             dout_valid,
  output logic             dout_first,
  output logic             dout_last,
  output logic [SYM_W-1:0] num_corr,
  output logic             corr_done,
`ifdef RS_CORR_STATS_EN
  output logic [15:0]      cw_count,
  output logic [15:0]      fail_count,
`endif
  output logic             corr_fail
);

  state_e           state_q, state_d;
  logic             fail_q, fail_d;
  sym_t             run_cnt_q, run_cnt_d;
  sym_t             dataout_q, dataout_d;
  logic             valid_q, valid_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  sym_t             num_corr_q, num_corr_d;
  logic             done_q, done_d;
  logic             corr_fail_q, corr_fail_d;
`ifdef RS_CORR_STATS_EN
  logic [15:0]      cw_q, cw_d;
  logic [15:0]      fc_q, fc_d;
`endif

  logic             rd_c;
  logic             cnt_clr, cnt_en;
  logic [CNT_W-1:0] pos;
  logic             pos_last;
  sym_t             fix;

  rs_sym_counter u_pos (
    .clk_i   (clock),
    .rst_n_i (reset),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .cnt_o   (pos),
    .tc_o    (pos_last)
  );

  // A failed decode must pass the received word through untouched.
  assign fix = (err_loc && !fail_q) ? err_val : '0;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    fail_d      = fail_q;
    run_cnt_d   = run_cnt_q;
    dataout_d   = dataout_q;
    valid_d     = 1'b0;
    first_d     = 1'b0;
    last_d      = 1'b0;
    num_corr_d  = num_corr_q;
    done_d      = 1'b0;
    corr_fail_d = corr_fail_q;
    rd_c        = 1'b0;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
`ifdef RS_CORR_STATS_EN
    cw_d        = cw_q;
    fc_d        = fc_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          fail_d    = decode_fail;
          run_cnt_d = '0;
          cnt_clr   = 1'b1;
          rd_c      = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        // The symbol at pos is already on sym_in; no read needed after the last one.
        rd_c      = !pos_last;
        cnt_en    = 1'b1;
        dataout_d = sym_in ^ fix;
        valid_d   = 1'b1;
        first_d   = (pos == '0);
        last_d    = pos_last;
        if (fix != '0) begin
          run_cnt_d = SYM_W'(run_cnt_q + 1'b1);
        end
        if (pos_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d      = 1'b1;
        num_corr_d  = run_cnt_q;
        corr_fail_d = fail_q;
`ifdef RS_CORR_STATS_EN
        if (cw_q != 16'hFFFF) cw_d = cw_q + 16'd1;
        if (fail_q && (fc_q != 16'hFFFF)) fc_d = fc_q + 16'd1;
`endif
        state_d = IDLE;
        // Back-to-back codeword: accept start here for a one-cycle gap.
        if (start) begin
          fail_d    = decode_fail;
          run_cnt_d = '0;
          cnt_clr   = 1'b1;
          rd_c      = 1'b1;
          state_d   = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      fail_q      <= 1'b0;
      run_cnt_q   <= '0;
      dataout_q   <= '0;
      valid_q     <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      num_corr_q  <= '0;
      done_q      <= 1'b0;
      corr_fail_q <= 1'b0;
`ifdef RS_CORR_STATS_EN
      cw_q        <= '0;
      fc_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      fail_q      <= fail_d;
      run_cnt_q   <= run_cnt_d;
      dataout_q   <= dataout_d;
      valid_q     <= valid_d;
      first_q     <= first_d;
      last_q      <= last_d;
      num_corr_q  <= num_corr_d;
      done_q      <= done_d;
      corr_fail_q <= corr_fail_d;
`ifdef RS_CORR_STATS_EN
      cw_q        <= cw_d;
      fc_q        <= fc_d;
`endif
    end
  end

  // Read strobe is combinational; gating with reset keeps it low while reset is held.
  assign fifo_rd    = rd_c & reset;
  assign dataout    = dataout_q;
  assign dout_valid = valid_q;
  assign dout_first = first_q;
  assign dout_last  = last_q;
  assign num_corr   = num_corr_q;
  assign corr_done  = done_q;
  assign corr_fail  = corr_fail_q;
`ifdef RS_CORR_STATS_EN
  assign cw_count   = cw_q;
  assign fail_count = fc_q;
`endif

endmodule
